// File: rtl/note_pkg.sv
`default_nettype none
// ============================================================================
// Module      : note_pkg
// Description : Shared lane/column sizes, lane colours and hit-window helper
//               for the note-lane scroller.
// Revision    : 1.0 - initial release
// ============================================================================
package note_pkg;

    localparam int NUM_LANES   = 7;
    localparam int NUM_COLS    = 64;
    localparam int DEF_HIT_COL = 6;
    localparam int DEF_HIT_WIN = 2;

    localparam logic [2:0] LANE_COLOR [0:NUM_LANES-1] = '{
        3'b100, 3'b010, 3'b001, 3'b110, 3'b011, 3'b101, 3'b111
    };

    function automatic logic [NUM_COLS-1:0] windowMask(input int col, input int win);
        logic [NUM_COLS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if ((i >= col - win) && (i <= col + win)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/note_lane.sv
`default_nettype none
// ============================================================================
// Module      : note_lane
// Description : One note lane: occupancy register, hit-window search,
//               scroll/spawn update and registered hit/miss pulses.
//               Optional: NOTE_GHOST_PENALTY_EN (press on empty window = miss).
// Revision    : 1.0 - initial release
// ============================================================================
module note_lane
    import note_pkg::*;
#(
    parameter int HIT_COL = DEF_HIT_COL,
    parameter int HIT_WIN = DEF_HIT_WIN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                clr,
    input  logic                tick,
    input  logic                press,
    input  logic                spawn,
    output logic [NUM_COLS-1:0] occ,
    output logic                hitNext,
    output logic                hitPulse,
    output logic                missPulse
);

    localparam logic [NUM_COLS-1:0] C_WIN = windowMask(HIT_COL, HIT_WIN);

    logic [NUM_COLS-1:0] r_occ;
    logic                r_hit;
    logic                r_miss;
    logic [NUM_COLS-1:0] w_cand;
    logic [NUM_COLS-1:0] w_hitClear;
    logic [NUM_COLS-1:0] w_a;
    logic [NUM_COLS-1:0] w_next;
    logic                w_missNext;

    always_comb begin
        w_cand     = r_occ & C_WIN;
        // Isolating the lowest set bit picks the note closest to column 0.
        w_hitClear = press ? (w_cand & (~w_cand + NUM_COLS'(1))) : '0;
        w_a        = r_occ & ~w_hitClear;
        w_next     = tick ? (w_a >> 1) : w_a;
        if (spawn) w_next[NUM_COLS-1] = 1'b1;
        hitNext    = |w_hitClear;
`ifdef NOTE_GHOST_PENALTY_EN
        w_missNext = (tick && w_a[0]) || (press && !(|w_cand));
`else
        w_missNext = tick && w_a[0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_occ  <= '0;
            r_hit  <= 1'b0;
            r_miss <= 1'b0;
        end else if (!enable) begin
            r_hit  <= 1'b0;
            r_miss <= 1'b0;
        end else begin
            r_occ  <= w_next;
            r_hit  <= hitNext;
            r_miss <= w_missNext;
        end
    end

    assign occ       = r_occ;
    assign hitPulse  = r_hit;
    assign missPulse = r_miss;

endmodule
`default_nettype wire

// File: rtl/note_lane_scroller.sv
`default_nettype none
// ============================================================================
// Module      : note_lane_scroller
// Description : Seven scrolling note lanes with hit judgement, saturating hit
//               counter and RGB lane bitmaps for the LED matrix.
//               Optional: NOTE_GHOST_PENALTY_EN (handled in note_lane).
// Revision    : 1.0 - initial release
// ============================================================================
module note_lane_scroller
    import note_pkg::*;
#(
    parameter int SCROLL_DIV = 500000,
    parameter int HIT_COL    = DEF_HIT_COL,
    parameter int HIT_WIN    = DEF_HIT_WIN,
    parameter int CNT_MAX    = 9999
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clr,
    input  logic                  spawn_valid,
    input  logic [2:0]            spawn_lane,
    output logic                  spawn_ready,
    input  logic [NUM_LANES-1:0]  btn,
    output logic [NUM_LANES-1:0]  hit_mask,
    output logic [NUM_LANES-1:0]  miss_mask,
    output logic [13:0]           hit_count,
    output logic [3*NUM_COLS-1:0] notesMap0,
    output logic [3*NUM_COLS-1:0] notesMap1,
    output logic [3*NUM_COLS-1:0] notesMap2,
    output logic [3*NUM_COLS-1:0] notesMap3,
    output logic [3*NUM_COLS-1:0] notesMap4,
    output logic [3*NUM_COLS-1:0] notesMap5,
    output logic [3*NUM_COLS-1:0] notesMap6
);

    localparam int C_PW = (SCROLL_DIV > 2) ? $clog2(SCROLL_DIV) : 1;

    logic [C_PW-1:0]       r_presc;
    logic [NUM_LANES-1:0]  r_btnD;
    logic [13:0]           r_hitCount;
    logic                  w_tick;
    logic [NUM_LANES-1:0]  w_press;
    logic [NUM_LANES-1:0]  w_hitNext;
    logic [NUM_LANES:0]    w_top;
    logic                  w_spawnAcc;
    logic [2:0]            w_pop;
    logic [14:0]           w_sum;
    logic [NUM_COLS-1:0]   w_occ [NUM_LANES];
    logic [3*NUM_COLS-1:0] w_map [NUM_LANES];

    assign w_tick  = enable && (r_presc == C_PW'(SCROLL_DIV - 1));
    assign w_press = btn & ~r_btnD & {NUM_LANES{enable}};

    // Bit NUM_LANES stands in for the invalid lane 7 so it always reads full.
    assign w_top[NUM_LANES] = 1'b1;
    assign spawn_ready = enable && !clr && (spawn_lane < 3'(NUM_LANES))
                         && (w_tick || !w_top[spawn_lane]);
    assign w_spawnAcc  = spawn_valid && spawn_ready;

    for (genvar gl = 0; gl < NUM_LANES; gl++) begin : g_lane
        note_lane #(
            .HIT_COL (HIT_COL),
            .HIT_WIN (HIT_WIN)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .enable    (enable),
            .clr       (clr),
            .tick      (w_tick),
            .press     (w_press[gl]),
            .spawn     (w_spawnAcc && (spawn_lane == 3'(gl))),
            .occ       (w_occ[gl]),
            .hitNext   (w_hitNext[gl]),
            .hitPulse  (hit_mask[gl]),
            .missPulse (miss_mask[gl])
        );

        assign w_top[gl] = w_occ[gl][NUM_COLS-1];

        for (genvar gc = 0; gc < NUM_COLS; gc++) begin : g_col
            assign w_map[gl][3*gc +: 3] = w_occ[gl][gc] ? LANE_COLOR[gl] : 3'b000;
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_LANES; i++) w_pop = w_pop + 3'(w_hitNext[i]);
        w_sum = {1'b0, r_hitCount} + 15'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_presc <= '0;
        end else if (enable) begin
            r_presc <= w_tick ? '0 : r_presc + C_PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_btnD <= '0;
        else     r_btnD <= btn;
    end

    always_ff @(posedge clk) begin
        if (rst || clr)                  r_hitCount <= '0;
        else if (w_sum > 15'(CNT_MAX))   r_hitCount <= 14'(CNT_MAX);
        else                             r_hitCount <= w_sum[13:0];
    end

    assign hit_count = r_hitCount;
    assign notesMap0 = w_map[0];
    assign notesMap1 = w_map[1];
    assign notesMap2 = w_map[2];
    assign notesMap3 = w_map[3];
    assign notesMap4 = w_map[4];
    assign notesMap5 = w_map[5];
    assign notesMap6 = w_map[6];

endmodule
`default_nettype wire

// File: tb/tb_note_lane_scroller.sv
`default_nettype none
// ============================================================================
// Module      : tb_note_lane_scroller
// Description : Randomized bench for note_lane_scroller against a note-list
//               reference model (notes kept as column positions per lane).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_note_lane_scroller;

    localparam int DIV  = 4;
    localparam int CMAX = 20;
    localparam int HC   = 6;
    localparam int HW   = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         clr;
    logic         spawn_valid;
    logic [2:0]   spawn_lane;
    logic [6:0]   btn;
    logic         spawn_ready;
    logic [6:0]   hit_mask;
    logic [6:0]   miss_mask;
    logic [13:0]  hit_count;
    logic [191:0] obsMap [7];

    always #5 clk = ~clk;

    note_lane_scroller #(
        .SCROLL_DIV (DIV),
        .HIT_COL    (HC),
        .HIT_WIN    (HW),
        .CNT_MAX    (CMAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .clr         (clr),
        .spawn_valid (spawn_valid),
        .spawn_lane  (spawn_lane),
        .spawn_ready (spawn_ready),
        .btn         (btn),
        .hit_mask    (hit_mask),
        .miss_mask   (miss_mask),
        .hit_count   (hit_count),
        .notesMap0   (obsMap[0]),
        .notesMap1   (obsMap[1]),
        .notesMap2   (obsMap[2]),
        .notesMap3   (obsMap[3]),
        .notesMap4   (obsMap[4]),
        .notesMap5   (obsMap[5]),
        .notesMap6   (obsMap[6])
    );

    int         vecs = 0;
    int         errs = 0;
    int         notes [7][$];
    int         mCnt;
    int         mPresc;
    logic [6:0] mBtnD;
    logic [6:0] mHit;
    logic [6:0] mMiss;
    logic [2:0] color [7] = '{3'b100, 3'b010, 3'b001, 3'b110, 3'b011, 3'b101, 3'b111};

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [191:0] expMap(input int L);
        logic [191:0] m;
        m = '0;
        foreach (notes[L][k]) m[3*notes[L][k] +: 3] = color[L];
        return m;
    endfunction

    function automatic bit has63(input int L);
        foreach (notes[L][k]) if (notes[L][k] == 63) return 1'b1;
        return 1'b0;
    endfunction

    task automatic modelClear();
        for (int L = 0; L < 7; L++) notes[L] = {};
        mCnt   = 0;
        mPresc = 0;
        mHit   = '0;
        mMiss  = '0;
    endtask

    task automatic checkOutputs();
        chk("hitMask",  192'(hit_mask),  192'(mHit));
        chk("missMask", 192'(miss_mask), 192'(mMiss));
        chk("hitCount", 192'(hit_count), 192'(mCnt));
        for (int L = 0; L < 7; L++) chk($sformatf("map%0d", L), obsMap[L], expMap(L));
    endtask

    // Inputs must already be driven; applies one clock and checks the result.
    task automatic step();
        bit tick;
        bit ready;
        int nq [$];
        #1;
        tick  = enable && (mPresc == DIV - 1);
        ready = 1'b0;
        if (enable && !clr && spawn_lane < 7)
            ready = tick || !has63(int'(spawn_lane));
        chk("spawnReady", 192'(spawn_ready), 192'(ready));

        mHit  = '0;
        mMiss = '0;
        if (clr) begin
            modelClear();
        end else if (enable) begin
            for (int L = 0; L < 7; L++) begin
                if (btn[L] && !mBtnD[L]) begin
                    int bi;
                    int best;
                    bi   = -1;
                    best = 1000;
                    foreach (notes[L][k]) begin
                        if (notes[L][k] >= HC - HW && notes[L][k] <= HC + HW && notes[L][k] < best) begin
                            best = notes[L][k];
                            bi   = k;
                        end
                    end
                    if (bi >= 0) begin
                        notes[L].delete(bi);
                        mHit[L] = 1'b1;
                    end
`ifdef NOTE_GHOST_PENALTY_EN
                    else mMiss[L] = 1'b1;
`endif
                end
                if (tick) begin
                    nq = {};
                    foreach (notes[L][k]) begin
                        if (notes[L][k] == 0) mMiss[L] = 1'b1;
                        else nq.push_back(notes[L][k] - 1);
                    end
                    notes[L] = nq;
                end
            end
            if (spawn_valid && ready) notes[spawn_lane].push_back(63);
            mCnt = mCnt + $countones(mHit);
            if (mCnt > CMAX) mCnt = CMAX;
            mPresc = tick ? 0 : mPresc + 1;
        end
        mBtnD = btn;

        @(posedge clk);
        #1;
        checkOutputs();
        @(negedge clk);
    endtask

    task automatic randomCycles(input int n, input int pressOdds, input int spawnOdds);
        logic [6:0] flip;
        for (int i = 0; i < n; i++) begin
            enable      = ($urandom_range(0, 19) != 0);
            clr         = ($urandom_range(0, 599) == 0);
            spawn_valid = ($urandom_range(0, spawnOdds) == 0);
            spawn_lane  = 3'($urandom_range(0, 7));
            for (int b = 0; b < 7; b++) flip[b] = ($urandom_range(0, pressOdds) == 0);
            btn = btn ^ flip;
            step();
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; clr = 1'b0;
        spawn_valid = 1'b0; spawn_lane = '0; btn = '0;
        modelClear();
        mBtnD = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rstReady", 192'(spawn_ready), 192'(0));
        checkOutputs();
        @(negedge clk);

        // First spawn on lane 2 lights column 63 in blue.
        enable = 1'b1; spawn_valid = 1'b1; spawn_lane = 3'd2;
        step();
        chk("spawnLane2Col63", 192'(obsMap[2][191:189]), 192'(3'b001));
        spawn_valid = 1'b0;

        randomCycles(3000, 6, 3);

        // Freeze with buttons held; the held level must not register on resume.
        enable = 1'b0; btn = 7'h7f; spawn_valid = 1'b1; clr = 1'b0;
        repeat (100) step();
        enable = 1'b1;
        repeat (20) step();

        // Dense traffic drives the counter into saturation, then a clear.
        randomCycles(1500, 1, 0);
        enable = 1'b1; clr = 1'b1;
        step();
        clr = 1'b0; spawn_valid = 1'b0;
        step();

        randomCycles(500, 3, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
